// File: rtl/spi_cfg_sequencer.sv
// Board bring-up sequencer: walks enabled SPI config engines in index order,
// muxing the shared spi_master command bus and chip-select to one engine at a time.
module spi_cfg_sequencer #(
    parameter int NUM_DEV         = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int LOCK_DEV        = 0,
    parameter int SCLK_DIV_LOG2   = 6,
    parameter int TIMEOUT_CYC     = 2**20,
    parameter int GAP_CYC         = 16
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 soft_rst,
    input  logic                                 i_cfg_start,
    input  logic [NUM_DEV-1:0]                   i_dev_en,
    input  logic                                 i_lock,
    output logic                                 o_cfg_busy,
    output logic                                 o_cfg_done,
    output logic                                 o_cfg_err,
    output logic [(NUM_DEV>1 ? $clog2(NUM_DEV) : 1)-1:0] o_err_dev,
    output logic [NUM_DEV-1:0]                   o_dev_start,
    input  logic [NUM_DEV-1:0]                   i_dev_done,
    input  logic [NUM_DEV-1:0]                   i_dev_wr_cmd,
    input  logic [NUM_DEV-1:0]                   i_dev_rd_cmd,
    input  logic [NUM_DEV*MOSI_DATA_WIDTH-1:0]   i_dev_wr_data,
    output logic [MISO_DATA_WIDTH:0]             o_dev_rd_data,
    output logic [NUM_DEV-1:0]                   o_dev_busy,
    output logic                                 o_spi_wr_cmd,
    output logic                                 o_spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]           o_spi_wr_data,
    input  logic [MISO_DATA_WIDTH:0]             i_spi_rd_data,
    input  logic                                 i_spi_busy,
    input  logic                                 i_spi_ncs,
    output logic                                 o_spi_clk,
    output logic [NUM_DEV-1:0]                   o_cs_n
);

    localparam int PW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int GW = $clog2(GAP_CYC + 1) + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [2:0]               state;
    logic [PW-1:0]            ptr;
    logic [NUM_DEV-1:0]       en_mask;
    logic [TW-1:0]            tmo;
    logic [GW-1:0]            gap_cnt;
    logic [SCLK_DIV_LOG2-1:0] cnt;
    logic                     start_r;
    logic                     edge_r;
    logic                     last;
    logic                     run_done;
    logic                     gap_ok;

    assign last     = (ptr == PW'(NUM_DEV - 1));
    assign run_done = i_dev_done[ptr] | ((ptr == PW'(LOCK_DEV)) & i_lock);
    assign gap_ok   = (GAP_CYC == 0) || (gap_cnt >= GW'(GAP_CYC - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            ptr        <= '0;
            en_mask    <= '0;
            tmo        <= '0;
            gap_cnt    <= '0;
            cnt        <= '0;
            start_r    <= 1'b0;
            edge_r     <= 1'b0;
            o_cfg_done <= 1'b0;
            o_cfg_err  <= 1'b0;
            o_err_dev  <= '0;
        end else begin
            cnt        <= soft_rst ? '0 : cnt + 1'b1;
            start_r    <= i_cfg_start;
            edge_r     <= ~soft_rst & i_cfg_start & ~start_r;
            o_cfg_done <= 1'b0;
            if (soft_rst) begin
                state     <= IDLE;
                ptr       <= '0;
                o_cfg_err <= 1'b0;
                o_err_dev <= '0;
            end else begin
                case (state)
                    IDLE: if (edge_r) begin
                        state     <= SELECT;
                        en_mask   <= i_dev_en;
                        ptr       <= '0;
                        o_cfg_err <= 1'b0;
                    end
                    SELECT: begin
                        if (en_mask[ptr]) begin
                            state <= RUN;
                            tmo   <= '0;
                        end else if (last) begin
                            state <= DONE;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    // done takes priority over a coincident timeout
                    RUN: begin
                        if (run_done) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                            state <= ERR;
                        end else if (tmo != '1) begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt != GW'(GAP_CYC)) gap_cnt <= gap_cnt + 1'b1;
                        if (gap_ok && !i_spi_busy) begin
                            if (last) begin
                                state <= DONE;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= SELECT;
                            end
                        end
                    end
                    DONE: begin
                        o_cfg_done <= 1'b1;
                        state      <= IDLE;
                    end
                    ERR: begin
                        o_cfg_err <= 1'b1;
                        o_err_dev <= ptr;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_dev_start   = '0;
        o_cs_n        = '1;
        o_dev_busy    = '1;
        o_spi_wr_cmd  = 1'b0;
        o_spi_rd_cmd  = 1'b0;
        o_spi_wr_data = '0;
        if (state == RUN) begin
            o_dev_start[ptr] = 1'b1;
            o_cs_n[ptr]      = i_spi_ncs;
            o_dev_busy[ptr]  = i_spi_busy;
            o_spi_wr_cmd     = i_dev_wr_cmd[ptr];
            o_spi_rd_cmd     = i_dev_rd_cmd[ptr];
            o_spi_wr_data    = i_dev_wr_data[ptr*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
        end
    end

    assign o_cfg_busy    = (state != IDLE);
    assign o_dev_rd_data = i_spi_rd_data;
    assign o_spi_clk     = cnt[SCLK_DIV_LOG2-1];

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with simple engine models
// that finish a fixed number of cycles after being started.
module tb_spi_cfg_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        soft_rst;
    logic        i_cfg_start;
    logic [2:0]  i_dev_en;
    logic        i_lock;
    logic        o_cfg_busy;
    logic        o_cfg_done;
    logic        o_cfg_err;
    logic [1:0]  o_err_dev;
    logic [2:0]  o_dev_start;
    logic [2:0]  i_dev_done;
    logic [2:0]  i_dev_wr_cmd;
    logic [2:0]  i_dev_rd_cmd;
    logic [71:0] i_dev_wr_data;
    logic [8:0]  o_dev_rd_data;
    logic [2:0]  o_dev_busy;
    logic        o_spi_wr_cmd;
    logic        o_spi_rd_cmd;
    logic [23:0] o_spi_wr_data;
    logic [8:0]  i_spi_rd_data;
    logic        i_spi_busy;
    logic        i_spi_ncs;
    logic        o_spi_clk;
    logic [2:0]  o_cs_n;

    spi_cfg_sequencer #(
        .NUM_DEV(3), .MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .LOCK_DEV(0),
        .SCLK_DIV_LOG2(6), .TIMEOUT_CYC(1000), .GAP_CYC(16)
    ) dut (
        .clk(clk), .nrst(nrst), .soft_rst(soft_rst), .i_cfg_start(i_cfg_start),
        .i_dev_en(i_dev_en), .i_lock(i_lock), .o_cfg_busy(o_cfg_busy),
        .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err), .o_err_dev(o_err_dev),
        .o_dev_start(o_dev_start), .i_dev_done(i_dev_done),
        .i_dev_wr_cmd(i_dev_wr_cmd), .i_dev_rd_cmd(i_dev_rd_cmd),
        .i_dev_wr_data(i_dev_wr_data), .o_dev_rd_data(o_dev_rd_data),
        .o_dev_busy(o_dev_busy), .o_spi_wr_cmd(o_spi_wr_cmd),
        .o_spi_rd_cmd(o_spi_rd_cmd), .o_spi_wr_data(o_spi_wr_data),
        .i_spi_rd_data(i_spi_rd_data), .i_spi_busy(i_spi_busy),
        .i_spi_ncs(i_spi_ncs), .o_spi_clk(o_spi_clk), .o_cs_n(o_cs_n)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic ncs_hold = 1'b0;
    always @(posedge clk) cyc++;
    assign i_spi_ncs = ncs_hold ? 1'b0 : cyc[2];

    int errors = 0;
    int checks = 0;

    // engine models
    int eng_cnt[3];
    int done_after[3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_dev_start[i]) eng_cnt[i]++;
            else eng_cnt[i] = 0;
            i_dev_done[i] = (done_after[i] != 0) && (eng_cnt[i] >= done_after[i]);
        end
    end

    // observation monitor
    int         done_cnt, done_cyc, nstarts, gap_len, min_gap, cs_bad;
    int         run_len[3];
    logic       seen_run;
    logic [2:0] starts[8];
    logic [2:0] prev_start, cs_low;

    always @(negedge clk) begin
        if (o_cfg_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_dev_start != 3'b000 && o_dev_start != prev_start) begin
            if (nstarts < 8) starts[nstarts] = o_dev_start;
            nstarts++;
            if (seen_run && gap_len < min_gap) min_gap = gap_len;
            seen_run = 1'b1;
        end
        if (o_dev_start == 3'b000) gap_len++;
        else gap_len = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_dev_start[i]) run_len[i]++;
            if (!o_dev_start[i] && !o_cs_n[i]) cs_bad++;
            if (o_dev_start[i] && o_cs_n[i] !== i_spi_ncs) cs_bad++;
            if (!o_cs_n[i]) cs_low[i] = 1'b1;
        end
        prev_start = o_dev_start;
    end

    task automatic clear_mon();
        done_cnt = 0; done_cyc = 0; nstarts = 0; gap_len = 0;
        min_gap = 1000000; cs_bad = 0; seen_run = 1'b0;
        cs_low = 3'b000; prev_start = o_dev_start;
        for (int i = 0; i < 3; i++) run_len[i] = 0;
        for (int i = 0; i < 8; i++) starts[i] = 3'b000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int c0;
    task automatic pulse_start();
        @(negedge clk);
        i_cfg_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        i_cfg_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (o_cfg_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < max, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input logic [2:0] v, input int max);
        int n = 0;
        while (o_dev_start !== v && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < max, 1);
    endtask

    initial begin
        nrst = 1'b0; soft_rst = 1'b0; i_cfg_start = 1'b0;
        i_dev_en = 3'b111; i_lock = 1'b0;
        i_dev_wr_cmd = 3'b111; i_dev_rd_cmd = 3'b100;
        i_dev_wr_data = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
        i_spi_rd_data = 9'h1A5; i_spi_busy = 1'b0;
        for (int i = 0; i < 3; i++) done_after[i] = 100;
        clear_mon();
        repeat (3) @(negedge clk);

        chk("rst_cs_n", o_cs_n, 3'b111);
        chk("rst_dev_busy", o_dev_busy, 3'b111);
        chk("rst_dev_start", o_dev_start, 3'b000);
        chk("rst_flags", {o_cfg_busy, o_cfg_done, o_cfg_err, o_err_dev}, 5'b0);
        chk("rst_spi_cmd", {o_spi_wr_cmd, o_spi_rd_cmd}, 2'b00);
        chk("rst_spi_clk", o_spi_clk, 1'b0);
        chk("rd_passthru", o_dev_rd_data, 9'h1A5);

        nrst = 1'b1;
        repeat (31) @(posedge clk);
        #1 chk("sclk_low_31", o_spi_clk, 1'b0);
        @(posedge clk);
        #1 chk("sclk_high_32", o_spi_clk, 1'b1);

        // full sequence, all enabled, with mux checks in device 1's step
        clear_mon();
        pulse_start();
        wait_start("t1_wait_dev1", 3'b010, 2000);
        #1;
        chk("t1_wr_cmd", o_spi_wr_cmd, 1'b1);
        chk("t1_rd_cmd", o_spi_rd_cmd, 1'b0);
        chk("t1_wr_data", o_spi_wr_data, 24'hBBBBBB);
        chk("t1_dev_busy", o_dev_busy, 3'b101);
        chk("t1_cs_unsel", o_cs_n & 3'b101, 3'b101);
        chk("t1_busy", o_cfg_busy, 1'b1);
        wait_idle("t1_idle", 5000);
        chk("t1_nstarts", nstarts, 3);
        chk("t1_order0", starts[0], 3'b001);
        chk("t1_order1", starts[1], 3'b010);
        chk("t1_order2", starts[2], 3'b100);
        chk("t1_run0", run_len[0], 100);
        chk("t1_run1", run_len[1], 100);
        chk("t1_run2", run_len[2], 100);
        chk("t1_min_gap", min_gap, 17);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", o_cfg_err, 1'b0);
        chk("t1_cs_follow", cs_bad, 0);
        chk("t1_cs_low", cs_low, 3'b111);
        chk("t1_idle_cmds", {o_spi_wr_cmd, o_spi_rd_cmd}, 2'b00);
        chk("t1_idle_data", o_spi_wr_data, 24'h0);

        // clock chip already locked: device 0 step is one cycle
        clear_mon();
        i_lock = 1'b1;
        pulse_start();
        wait_idle("t2_idle", 5000);
        i_lock = 1'b0;
        chk("t2_run0", run_len[0], 1);
        chk("t2_run1", run_len[1], 100);
        chk("t2_nstarts", nstarts, 3);
        chk("t2_done_cnt", done_cnt, 1);

        // device 1 disabled
        clear_mon();
        i_dev_en = 3'b101;
        pulse_start();
        wait_idle("t3_idle", 5000);
        chk("t3_nstarts", nstarts, 2);
        chk("t3_order1", starts[1], 3'b100);
        chk("t3_cs1_high", cs_low[1], 1'b0);
        chk("t3_done_cnt", done_cnt, 1);

        // empty mask: done NUM_DEV+1 cycles after acceptance
        clear_mon();
        i_dev_en = 3'b000;
        pulse_start();
        wait_idle("t3b_idle", 100);
        chk("t3b_done_lat", done_cyc - c0, 6);
        chk("t3b_nstarts", nstarts, 0);
        chk("t3b_done_cnt", done_cnt, 1);

        // device 1 never finishes: timeout
        clear_mon();
        i_dev_en = 3'b111;
        done_after[1] = 0;
        pulse_start();
        wait_idle("t4_idle", 5000);
        chk("t4_err", o_cfg_err, 1'b1);
        chk("t4_err_dev", o_err_dev, 2'd1);
        chk("t4_run1", run_len[1], 1000);
        chk("t4_nstarts", nstarts, 2);
        chk("t4_done_cnt", done_cnt, 0);
        done_after[1] = 100;
        clear_mon();
        pulse_start();
        chk("t4_err_clr", o_cfg_err, 1'b0);
        chk("t4_rerun_busy", o_cfg_busy, 1'b1);
        wait_idle("t4_rerun_idle", 5000);
        chk("t4_rerun_done", done_cnt, 1);

        // async reset mid-transfer of device 1
        clear_mon();
        pulse_start();
        wait_start("t5_wait_dev1", 3'b010, 2000);
        repeat (10) @(negedge clk);
        ncs_hold = 1'b1;
        #1 chk("t5_cs_active", o_cs_n, 3'b101);
        nrst = 1'b0;
        #1;
        chk("t5_cs_rst", o_cs_n, 3'b111);
        chk("t5_start_rst", o_dev_start, 3'b000);
        chk("t5_busy_rst", o_cfg_busy, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        ncs_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_pulse", {done_cnt[0], o_cfg_done, o_cfg_err}, 3'b000);
        clear_mon();
        pulse_start();
        wait_idle("t5_idle", 5000);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_nstarts", nstarts, 3);
        chk("t5_err", o_cfg_err, 1'b0);

        // start held high then re-pulsed mid-sequence
        clear_mon();
        @(negedge clk);
        i_cfg_start = 1'b1;
        wait_start("t6_wait_dev1", 3'b010, 2000);
        i_cfg_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_cfg_start = 1'b1;
        wait_idle("t6_idle", 5000);
        repeat (10) @(negedge clk);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_nstarts", nstarts, 3);
        chk("t6_busy", o_cfg_busy, 1'b0);
        i_cfg_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
